// File: rtl/viterbi_traceback_unit.sv
// Viterbi survivor memory and traceback: stores one decision vector per step, then walks back one step per cycle.
// Define TRACEBACK_FWD_ORDER_EN to buffer the decoded frame and emit it oldest-first.
module viterbi_traceback_unit #(
  parameter int K = 3,
  parameter int FRAME_LEN = 16,
  parameter int AW = $clog2(FRAME_LEN),
  localparam int SW = K - 1,
  localparam int NS = 1 << (K - 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [NS-1:0] in_dec,
  input  logic          in_last,
  input  logic [SW-1:0] start_node,
  output logic          in_ready,
  output logic          out_valid,
  output logic          out_bit,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  // state   | meaning
  // S_WRITE | accepting decision vectors into survivor memory
  // S_TRACE | walking the trellis backwards, one column per cycle
  // S_OUT   | forward-order emission of the buffered frame (optional)
  // S_DONE  | one-cycle completion pulse, rewind write pointer
  typedef enum logic [1:0] {S_WRITE, S_TRACE, S_OUT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [SW-1:0] node_q, node_d;
  logic [NS-1:0] mem_q [FRAME_LEN];
  logic [NS-1:0] mem_d [FRAME_LEN];

  logic          wr_en;
  logic          wr_final;
  logic          dec_bit;
  logic [SW:0]   node_shift;

`ifdef TRACEBACK_FWD_ORDER_EN
  logic [AW-1:0]        last_q, last_d;
  logic [AW-1:0]        oidx_q, oidx_d;
  logic [FRAME_LEN-1:0] bits_q, bits_d;
`endif

  assign wr_en      = in_valid && (state_q == S_WRITE);
  assign wr_final   = in_last || (wptr_q == AW'(FRAME_LEN - 1));
  assign dec_bit    = mem_q[rptr_q][node_q];
  // Shifting the survivor bit into the LSB recovers the predecessor state; works for SW == 1 too.
  assign node_shift = {node_q, dec_bit};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_WRITE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      node_q  <= '0;
`ifdef TRACEBACK_FWD_ORDER_EN
      last_q  <= '0;
      oidx_q  <= '0;
      bits_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      node_q  <= node_d;
`ifdef TRACEBACK_FWD_ORDER_EN
      last_q  <= last_d;
      oidx_q  <= oidx_d;
      bits_q  <= bits_d;
`endif
    end
  end

  // Survivor memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WRITE: if (wr_en && wr_final) state_d = S_TRACE;
`ifdef TRACEBACK_FWD_ORDER_EN
      S_TRACE: if (rptr_q == '0) state_d = S_OUT;
      S_OUT:   if (oidx_q == last_q) state_d = S_DONE;
`else
      S_TRACE: if (rptr_q == '0) state_d = S_DONE;
`endif
      S_DONE:  state_d = S_WRITE;
      default: state_d = S_WRITE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    node_d = node_q;
    mem_d  = mem_q;
`ifdef TRACEBACK_FWD_ORDER_EN
    last_d = last_q;
    oidx_d = oidx_q;
    bits_d = bits_q;
`endif
    case (state_q)
      S_WRITE: begin
        if (wr_en) begin
          mem_d[wptr_q] = in_dec;
          if (wr_final) begin
            node_d = start_node;
            rptr_d = wptr_q;
`ifdef TRACEBACK_FWD_ORDER_EN
            last_d = wptr_q;
`endif
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      S_TRACE: begin
        node_d = node_shift[SW-1:0];
        if (rptr_q != '0) rptr_d = rptr_q - AW'(1);
`ifdef TRACEBACK_FWD_ORDER_EN
        bits_d[rptr_q] = node_q[SW-1];
        oidx_d = '0;
`endif
      end
`ifdef TRACEBACK_FWD_ORDER_EN
      S_OUT: begin
        if (oidx_q != last_q) oidx_d = oidx_q + AW'(1);
      end
`endif
      S_DONE: wptr_d = '0;
      default: ;
    endcase
  end

  always_comb begin
    in_ready = rst && (state_q == S_WRITE);
    done     = (state_q == S_DONE);
`ifdef TRACEBACK_FWD_ORDER_EN
    out_valid = (state_q == S_OUT);
    out_bit   = (state_q == S_OUT) ? bits_q[oidx_q] : 1'b0;
    out_idx   = (state_q == S_OUT) ? oidx_q : '0;
    busy      = (state_q == S_TRACE) || (state_q == S_OUT);
`else
    out_valid = (state_q == S_TRACE);
    out_bit   = (state_q == S_TRACE) ? node_q[SW-1] : 1'b0;
    out_idx   = (state_q == S_TRACE) ? rptr_q : '0;
    busy      = (state_q == S_TRACE);
`endif
  end

endmodule
